keypad_entry_controller: RTL and testbench

- Sequences the keypad priority encoder: drives its active-low enable, debounces its 4-bit code/valid output, and shifts accepted digits into a 4-digit BCD MM:SS entry register.
- Issues a one-cycle load strobe to the timer on start.
- Sits between the priority encoder and the timer/countdown block in the timer-entry-and-control level.

---
 rtl/keypad_entry_controller_pkg.sv | 29 ++
 rtl/keypad_entry_controller_debouncer.sv | 114 +++++++++++
 rtl/keypad_entry_controller.sv | 104 ++++++++++
 tb/tb_keypad_entry_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_controller_pkg.sv
// ============================================================================
// Module   : keypad_entry_controller_pkg
// Shared state encoding, BCD limits and helpers for keypad entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

package keypad_entry_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int         KEY_W        = 4;
    localparam int         DIGITS       = 4;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Digit count saturates at the number of display digits.
    function automatic logic [2:0] sat_inc(input logic [2:0] count);
        return (count >= 3'(DIGITS)) ? 3'(DIGITS) : count + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_entry_controller_debouncer.sv
// ============================================================================
// Module   : key_debouncer
// Press/release debounce FSM; one-cycle accept pulse with the accepted code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_debouncer
    import keypad_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] code,
    input  logic             valid,
    input  logic             busy,
    output logic             accept,
    output logic [KEY_W-1:0] accept_code,
    output state_t           state,
    output state_t           state_next
);

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [KEY_W-1:0] latched;
    logic [KEY_W-1:0] latched_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            latched <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            latched <= latched_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latched_next = latched;
        accept       = 1'b0;
        accept_code  = latched;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (busy) begin
                    state_next = ST_LOCKED;
                end else if (valid && (code <= BCD_MAX)) begin
                    latched_next = code;
                    // A single-cycle debounce accepts straight from IDLE.
                    if (TARGET == ONE) begin
                        accept      = 1'b1;
                        accept_code = code;
                        state_next  = ST_RELEASE;
                    end else begin
                        cnt_next   = ONE;
                        state_next = ST_PRESS;
                    end
                end
            end
            ST_PRESS: begin
                if (busy) begin
                    cnt_next   = '0;
                    state_next = ST_LOCKED;
                end else if (valid && (code == latched)) begin
                    if (cnt + ONE == TARGET) begin
                        accept     = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_RELEASE;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (busy) begin
                    cnt_next   = '0;
                    state_next = ST_LOCKED;
                end else if (valid) begin
                    cnt_next = '0;
                end else if (cnt + ONE == TARGET) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            ST_LOCKED: begin
                cnt_next = '0;
                if (!busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/keypad_entry_controller.sv
// ============================================================================
// Module   : keypad_entry_controller
// Keypad digit entry into a BCD MM:SS register with start/load handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_entry_controller
    import keypad_entry_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] D,
    input  logic             valid,
    input  logic             start,
    input  logic             clear,
    input  logic             timer_busy,
    output logic             enablen,
    output logic [3:0]       min_tens,
    output logic [3:0]       min_ones,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic [2:0]       digit_count,
    output logic             load
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [KEY_W-1:0] accept_code;
    logic             start_d;
    logic             start_edge;
    logic             do_clear;
    logic             do_load;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clk         (clk),
        .reset       (reset),
        .code        (D),
        .valid       (valid),
        .busy        (timer_busy),
        .accept      (accept),
        .accept_code (accept_code),
        .state       (state),
        .state_next  (state_next)
    );

    assign start_edge = start && !start_d;
    assign do_clear   = clear && (state != ST_LOCKED);
    // Every start edge is consumed; only a clean one in IDLE with digits loads.
    assign do_load    = start_edge && (state == ST_IDLE) && !timer_busy &&
                        (digit_count != 3'd0) && !do_clear && !accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_d     <= 1'b0;
            enablen     <= 1'b1;
            load        <= 1'b0;
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_count <= 3'd0;
        end else begin
            start_d <= start;
            enablen <= (state_next == ST_LOCKED);
            load    <= do_load;
            if (do_clear) begin
                min_tens    <= 4'd0;
                min_ones    <= 4'd0;
                sec_tens    <= 4'd0;
                sec_ones    <= 4'd0;
                digit_count <= 3'd0;
            end else begin
                if (do_load) begin
                    if (sec_tens > SEC_TENS_MAX) begin
                        sec_tens <= SEC_TENS_MAX;
                        sec_ones <= BCD_MAX;
                    end
                end else if (accept) begin
                    min_tens <= min_ones;
                    min_ones <= sec_tens;
                    sec_tens <= sec_ones;
                    sec_ones <= accept_code;
                end
                // Count drops to zero the cycle after the load strobe.
                if (accept) begin
                    digit_count <= sat_inc(load ? 3'd0 : digit_count);
                end else if (load) begin
                    digit_count <= 3'd0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_controller.sv
// ============================================================================
// Module   : tb_keypad_entry_controller
// Randomized scoreboard bench for keypad_entry_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_entry_controller;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] D;
    logic       valid;
    logic       start;
    logic       clear;
    logic       timer_busy;
    logic       enablen;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;
    logic       load;

    keypad_entry_controller #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D           (D),
        .valid       (valid),
        .start       (start),
        .clear       (clear),
        .timer_busy  (timer_busy),
        .enablen     (enablen),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .digit_count (digit_count),
        .load        (load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [15:0] dig;
        logic [2:0]  cnt;
        logic        ld;
    } snap_t;

    snap_t       exp_q[$];
    snap_t       last;
    snap_t       e;
    int          md[4];
    int          mcnt;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [19:0] prev_obs;
    logic [19:0] obs;

    // Reference model: the entry is just a list of four digits and a count.
    task automatic commit(input int c, input logic ld);
        snap_t s;
        s.c   = c;
        s.dig = {md[0][3:0], md[1][3:0], md[2][3:0], md[3][3:0]};
        s.cnt = 3'(mcnt);
        s.ld  = ld;
        if ({s.dig, s.cnt, s.ld} != {last.dig, last.cnt, last.ld}) begin
            exp_q.push_back(s);
            last = s;
        end
    endtask

    task automatic model_accept(input int d);
        for (int i = 0; i < 3; i++) md[i] = md[i+1];
        md[3] = d;
        mcnt  = (mcnt < 4) ? mcnt + 1 : 4;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 4; i++) md[i] = 0;
        mcnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic press(input int d, input int hold, input int rel);
        int c0;
        c0 = cyc;
        if (d <= 9 && hold >= N) begin
            model_accept(d);
            commit(c0 + N, 1'b0);
        end
        valid = 1'b1;
        D     = 4'(d);
        step(hold);
        valid = 1'b0;
        step(rel);
    endtask

    task automatic clear_pulse();
        model_zero();
        commit(cyc + 1, 1'b0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic start_pulse(input bit with_clear);
        int c0;
        c0 = cyc;
        if (with_clear) begin
            model_zero();
            commit(c0 + 1, 1'b0);
        end else if (mcnt > 0) begin
            if (md[2] > 5) begin
                md[2] = 5;
                md[3] = 9;
            end
            commit(c0 + 1, 1'b1);
            mcnt = 0;
            commit(c0 + 2, 1'b0);
        end
        start = 1'b1;
        clear = with_clear;
        step(1);
        start = 1'b0;
        clear = 1'b0;
        step(2);
    endtask

    task automatic busy_session(input bit prepress);
        if (prepress) begin
            valid = 1'b1;
            D     = 4'($urandom_range(0, 9));
            step($urandom_range(1, N - 1));
        end
        timer_busy = 1'b1;
        step(1);
        chk("locked_enablen", 32'(enablen), 32'd1);
        valid = 1'b1;
        D     = 4'd5;
        step(N + 2);
        valid = 1'b0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("locked_hold_enablen", 32'(enablen), 32'd1);
        timer_busy = 1'b0;
        step(1);
        chk("unlock_enablen", 32'(enablen), 32'd0);
        step(1);
    endtask

    task automatic press_clear_at_accept(input int d);
        int c0;
        c0 = cyc;
        model_zero();
        commit(c0 + N, 1'b0);
        valid = 1'b1;
        D     = 4'(d);
        step(N - 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        valid = 1'b0;
        step(N + 1);
    endtask

    task automatic reset_mid_press(input int d);
        int c0;
        c0 = cyc;
        model_zero();
        commit(c0 + 3, 1'b0);
        valid = 1'b1;
        D     = 4'(d);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        valid = 1'b0;
        chk("reset_mid_enablen", 32'(enablen), 32'd1);
        step(N);
    endtask

    // Monitor: every visible change of the entry outputs must match the next expected snapshot.
    always @(negedge clk) begin
        if (mon_en) begin
            obs = {min_tens, min_ones, sec_tens, sec_ones, digit_count, load};
            if (obs !== prev_obs) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.c != cyc || obs !== {e.dig, e.cnt, e.ld}) begin
                        fails++;
                        $display("FAIL scoreboard actual=%h@cyc%0d required=%h@cyc%0d",
                                 obs, cyc, {e.dig, e.cnt, e.ld}, e.c);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        int d;
        reset      = 1'b1;
        valid      = 1'b0;
        D          = 4'd0;
        start      = 1'b0;
        clear      = 1'b0;
        timer_busy = 1'b0;
        step(3);
        chk("reset_digits", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'd0);
        chk("reset_count", 32'(digit_count), 32'd0);
        chk("reset_load", 32'(load), 32'd0);
        chk("reset_enablen", 32'(enablen), 32'd1);
        reset = 1'b0;
        model_zero();
        last.c   = 0;
        last.dig = 16'd0;
        last.cnt = 3'd0;
        last.ld  = 1'b0;
        prev_obs = {min_tens, min_ones, sec_tens, sec_ones, digit_count, load};
        mon_en   = 1'b1;
        step(1);
        chk("idle_enablen", 32'(enablen), 32'd0);

        press(3, N, N);
        press(7, 2, N);
        clear_pulse();
        for (int k = 1; k <= 5; k++) press(k, N, N);
        clear_pulse();
        press(1, N, N);
        press(8, N, N);
        press(9, N, N);
        start_pulse(1'b0);
        busy_session(1'b0);
        busy_session(1'b1);
        press(4, N + 2, N + 1);
        press(2, N, N);
        start_pulse(1'b1);
        press(6, N, N);
        press_clear_at_accept(6);
        press(5, N, N);
        reset_mid_press(8);
        press(12, N + 1, N);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                    : int'($urandom_range(0, 9));
                    press(d, $urandom_range(1, N + 3), $urandom_range(N, N + 2));
                end
                6: clear_pulse();
                7: start_pulse(1'b0);
                8: start_pulse(1'(($urandom_range(0, 3) == 0)));
                default: busy_session(1'($urandom_range(0, 1)));
            endcase
        end

        step(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
